// File: rtl/tt_um_ternary_pkg.sv
// Shared constants and types for the ternary MVM datapath and its output serializer.
package tt_um_ternary_pkg;

  localparam int MaxOutLen = 255;
  localparam int BitWidth  = 8;

  // int8 clip bounds as output bytes
  localparam logic [BitWidth-1:0] Int8MaxByte = 8'h7F;
  localparam logic [BitWidth-1:0] Int8MinByte = 8'h80;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_e;

endpackage

// File: rtl/tt_um_sat8.sv
// Saturates one signed accumulator value to int8 and flags when clipping altered it.
module tt_um_sat8
  import tt_um_ternary_pkg::*;
#(
  parameter int AccWidth = 12
) (
  input  logic signed [AccWidth-1:0] acc,
  output logic        [BitWidth-1:0] data,
  output logic                       clipped
);

  // The value fits in int8 exactly when bits [AccWidth-1:7] are all copies of the sign.
  logic [AccWidth-8:0] upper;
  assign upper = acc[AccWidth-1:7];

  always_comb begin
    clipped = !((&upper) || !(|upper));
    data    = acc[7:0];
    if (clipped) begin
      data = acc[AccWidth-1] ? Int8MinByte : Int8MaxByte;
    end
  end

endmodule

// File: rtl/tt_um_result_serializer.sv
// Captures one multiplier result vector and streams it out as bytes (narrow int8 or wide 16-bit).
module tt_um_result_serializer
  import tt_um_ternary_pkg::*;
#(
  parameter int OutLen   = 8,
  parameter int AccWidth = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [OutLen*AccWidth-1:0] in_vec,
  input  logic                       wide_mode,
  output logic [BitWidth-1:0]        out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last,
  output logic                       sat_flag,
  output ser_state_e                 dbg_state
);

  localparam int IdxW = (OutLen > 1) ? $clog2(OutLen) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(OutLen - 1);

  if (OutLen < 1 || OutLen > MaxOutLen || AccWidth < 9 || AccWidth > 16) begin : g_bad_param
    $error("tt_um_result_serializer: OutLen or AccWidth out of range");
  end

  // Handshake: a transfer happens on any rising edge where valid && ready are both high.
  // The producer holds data stable while valid && !ready; in_ready depends combinationally on
  // out_ready so a new vector can be taken on the same edge the last byte leaves.

  ser_state_e                 state_q, state_d;
  logic [OutLen*AccWidth-1:0] vec_q, vec_d;
  logic                       wide_q, wide_d;
  logic [IdxW-1:0]            idx_q, idx_d;
  logic                       sel_q, sel_d;

  logic signed [AccWidth-1:0] res [OutLen];
  logic signed [AccWidth-1:0] cur;
  logic signed [15:0]         ext;
  logic [BitWidth-1:0]        sat_data;
  logic                       sat_clip;
  logic                       xfer;
  logic                       capture;

  for (genvar i = 0; i < OutLen; i++) begin : g_unpack
    assign res[i] = vec_q[i*AccWidth +: AccWidth];
  end

  assign cur = res[idx_q];
  assign ext = 16'(cur);

  tt_um_sat8 #(
    .AccWidth(AccWidth)
  ) u_sat8 (
    .acc    (cur),
    .data   (sat_data),
    .clipped(sat_clip)
  );

  always_comb begin
    out_valid = (state_q == SEND);
    out_data  = '0;
    out_last  = 1'b0;
    sat_flag  = 1'b0;
    if (state_q == SEND) begin
      if (wide_q) begin
        out_data = sel_q ? ext[15:8] : ext[7:0];
        out_last = (idx_q == LastIdx) && sel_q;
      end else begin
        out_data = sat_data;
        sat_flag = sat_clip;
        out_last = (idx_q == LastIdx);
      end
    end
  end

  assign xfer      = out_valid && out_ready;
  assign in_ready  = !rst && ((state_q == IDLE) || (xfer && out_last));
  assign capture   = in_valid && in_ready;
  assign dbg_state = state_q;

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    wide_d  = wide_q;
    idx_d   = idx_q;
    sel_d   = sel_q;
    if (capture) begin
      state_d = SEND;
      vec_d   = in_vec;
      wide_d  = wide_mode;
      idx_d   = '0;
      sel_d   = 1'b0;
    end else if (xfer) begin
      if (out_last) begin
        state_d = IDLE;
      end else if (wide_q && !sel_q) begin
        sel_d = 1'b1;
      end else begin
        sel_d = 1'b0;
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
      wide_q  <= 1'b0;
      idx_q   <= '0;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      wide_q  <= wide_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
    end
  end

endmodule
